core_alu_wb: RTL and testbench

Execute-to-writeback stage of the i2d core. Captures each ALU result with its destination register, and commits the ALU carry/overflow/zero flags to the architectural status register. Drains results into the register-file write port under a request/grant handshake. It is the consumer side of the ALU's result and flag outputs and the producer of the `sr` flags the ALU reads back, so ADDC/SUBC chains see correct carries.

---
 rtl/core_alu_wb.sv | 111 +++++++++++
 tb/tb_core_alu_wb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_alu_wb.sv
// Execute-to-writeback stage: single-entry result buffer draining to the register file, plus flag commit.
// Optional bypass outputs are enabled by defining I2D_WB_FWD_EN.
module core_alu_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_rf_wen,
    input  logic              ex_sr_wen,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cf,
    input  logic              alu_of,
    input  logic              alu_zf,
    input  logic              flush,
    output logic              sr_cf,
    output logic              sr_of,
    output logic              sr_zf,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_gnt,
    output logic              fwd_valid,
    output logic [RA_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retired
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state, state_nxt;
    logic              pend_v;
    logic [RA_W-1:0]   pend_rd;
    logic [DATA_W-1:0] pend_data;
    logic              accept;
    logic              load;
    logic              retire;

    assign pend_v   = (state == FULL);
    assign ex_ready = ~pend_v | rf_gnt;
    assign accept   = ex_valid & ex_ready;
    assign retire   = pend_v & rf_gnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Flush beats both load and retire; r0 writes never create an entry
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (accept && ex_rf_wen && (ex_rd != RA_W'(0)) && !flush) begin
            load = 1'b1;
        end
        if (flush) begin
            state_nxt = EMPTY;
        end else if (load) begin
            state_nxt = FULL;
        end else if (retire) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rd   <= RA_W'(0);
            pend_data <= DATA_W'(0);
        end else if (load) begin
            pend_rd   <= ex_rd;
            pend_data <= alu_result;
        end
    end

    // Flags commit at accept so a dependent carry chain sees them next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_cf <= 1'b0;
            sr_of <= 1'b0;
            sr_zf <= 1'b0;
        end else if (accept && ex_sr_wen) begin
            sr_cf <= alu_cf;
            sr_of <= alu_of;
            sr_zf <= alu_zf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired <= 32'd0;
        else if (accept) retired <= retired + 32'd1;
    end

    assign rf_we    = pend_v;
    assign rf_waddr = pend_rd;
    assign rf_wdata = pend_data;

`ifdef I2D_WB_FWD_EN
    assign fwd_valid = pend_v;
    assign fwd_rd    = pend_rd;
    assign fwd_data  = pend_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = RA_W'(0);
    assign fwd_data  = DATA_W'(0);
`endif

endmodule

// File: tb/tb_core_alu_wb.sv
// Directed bench for core_alu_wb; register-file writes are checked against a scoreboard queue.
module tb_core_alu_wb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RA_W   = 5;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic              ex_ready;
    logic [RA_W-1:0]   ex_rd;
    logic              ex_rf_wen;
    logic              ex_sr_wen;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cf, alu_of, alu_zf;
    logic              flush;
    logic              sr_cf, sr_of, sr_zf;
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_gnt;
    logic              fwd_valid;
    logic [RA_W-1:0]   fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [31:0]       retired;

    int tests;
    int fails;
    logic [RA_W+DATA_W-1:0] sb[$];

    core_alu_wb #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
        .ex_rf_wen(ex_rf_wen), .ex_sr_wen(ex_sr_wen), .alu_result(alu_result),
        .alu_cf(alu_cf), .alu_of(alu_of), .alu_zf(alu_zf), .flush(flush),
        .sr_cf(sr_cf), .sr_of(sr_of), .sr_zf(sr_zf),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_gnt(rf_gnt),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RA_W-1:0] rd, input logic [DATA_W-1:0] d,
                         input logic rfw, input logic srw, input logic cf, input logic of, input logic zf);
        ex_valid   = v;
        ex_rd      = rd;
        alu_result = d;
        ex_rf_wen  = rfw;
        ex_sr_wen  = srw;
        alu_cf     = cf;
        alu_of     = of;
        alu_zf     = zf;
    endtask

    task automatic check_fwd(input logic [RA_W-1:0] rd, input logic [DATA_W-1:0] d);
`ifdef I2D_WB_FWD_EN
        check("fwd_valid", 32'(fwd_valid), 32'd1);
        check("fwd_rd", 32'(fwd_rd), 32'(rd));
        check("fwd_data", fwd_data, d);
`else
        check("fwd_valid_off", 32'(fwd_valid), 32'd0);
        check("fwd_rd_off", 32'(fwd_rd), 32'(RA_W'(0) & rd));
        check("fwd_data_off", fwd_data, 32'd0 & d);
`endif
    endtask

    // Register-file side: every granted write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && rf_we && rf_gnt) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $error("FAIL sb_unexpected: observed write rd=%0d data=%h expected none", rf_waddr, rf_wdata);
            end else begin
                logic [RA_W+DATA_W-1:0] e;
                e = sb.pop_front();
                assert ({rf_waddr, rf_wdata} === e) else begin
                    fails++;
                    $error("FAIL sb_write: observed %h expected %h", {rf_waddr, rf_wdata}, e);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n  = 1'b0;
        rf_gnt = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_sr", 32'({sr_cf, sr_of, sr_zf}), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_ready", 32'(ex_ready), 32'd1);
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        check("rst_fwd_data", fwd_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic accept with flag update
        rf_gnt = 1'b1;
        drive(1'b1, 5'd3, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        sb.push_back({5'd3, 32'h1234});
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_rf_we", 32'(rf_we), 32'd1);
        check("t1_waddr", 32'(rf_waddr), 32'd3);
        check("t1_wdata", rf_wdata, 32'h1234);
        check("t1_sr_cf", 32'(sr_cf), 32'd1);
        check("t1_sr_zf", 32'(sr_zf), 32'd0);
        check("t1_retired", retired, 32'd1);
        tick();
        check("t1_drained", 32'(rf_we), 32'd0);

        // Backpressure: entry holds while ungranted, then retire and accept in one cycle
        rf_gnt = 1'b0;
        drive(1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({5'd7, 32'h77});
        tick();
        drive(1'b1, 5'd8, 32'h88, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t2_ready_low", 32'(ex_ready), 32'd0);
        tick();
        check("t2_hold_we", 32'(rf_we), 32'd1);
        check("t2_hold_waddr", 32'(rf_waddr), 32'd7);
        check("t2_hold_wdata", rf_wdata, 32'h77);
        check("t2_hold_retired", retired, 32'd2);
        check("t2_sr_hold", 32'(sr_cf), 32'd1);
        rf_gnt = 1'b1;
        sb.push_back({5'd8, 32'h88});
        #1;
        check("t2_ready_gnt", 32'(ex_ready), 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_second_waddr", 32'(rf_waddr), 32'd8);
        check("t2_second_wdata", rf_wdata, 32'h88);
        check("t2_retired", retired, 32'd3);
        tick();
        check("t2_drained", 32'(rf_we), 32'd0);

        // r0 destination: flags update, no write
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_rf_we", 32'(rf_we), 32'd0);
        check("t3_sr_of", 32'(sr_of), 32'd1);
        check("t3_sr_cf", 32'(sr_cf), 32'd0);
        check("t3_retired", retired, 32'd4);

        // Flush with a simultaneous retire and accept
        rf_gnt = 1'b0;
        drive(1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back({5'd4, 32'h44});
        tick();
        check("t4_pend", 32'(rf_we), 32'd1);
        rf_gnt = 1'b1;
        flush  = 1'b1;
        drive(1'b1, 5'd5, 32'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_flush_we", 32'(rf_we), 32'd0);
        check("t4_flush_zf", 32'(sr_zf), 32'd1);
        check("t4_flush_of", 32'(sr_of), 32'd0);
        check("t4_retired", retired, 32'd6);
        tick();
        check("t4_stays_empty", 32'(rf_we), 32'd0);

        // Counter wrap
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        drive(1'b1, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_wrap", retired, 32'd0);
        check("t5_no_write", 32'(rf_we), 32'd0);

        // Forwarding view of a pending entry
        rf_gnt = 1'b0;
        drive(1'b1, 5'd9, 32'hA5A5_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        sb.push_back({5'd9, 32'hA5A5_0000});
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_rf_we", 32'(rf_we), 32'd1);
        check_fwd(5'd9, 32'hA5A5_0000);
        check("t6_sr_hold", 32'({sr_cf, sr_of, sr_zf}), 32'b001);
        rf_gnt = 1'b1;
        tick();
        check("t6_drained", 32'(rf_we), 32'd0);
        check("t6_fwd_clear", 32'(fwd_valid), 32'd0);

        // Sustained back-to-back with grant held high
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(10 + i), 32'(32'hB000 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            sb.push_back({5'(10 + i), 32'(32'hB000 + i)});
            #1;
            check("t7_ready", 32'(ex_ready), 32'd1);
            tick();
            check("t7_waddr", 32'(rf_waddr), 32'(10 + i));
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t7_retired", retired, 32'd5);
        tick();
        check("t7_drained", 32'(rf_we), 32'd0);

        // Reset drops a pending write
        rf_gnt = 1'b0;
        drive(1'b1, 5'd14, 32'hEE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t8_pend", 32'(rf_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t8_rst_we", 32'(rf_we), 32'd0);
        check("t8_rst_retired", retired, 32'd0);
        check("t8_rst_sr", 32'({sr_cf, sr_of, sr_zf}), 32'd0);
        #10;
        rst_n  = 1'b1;
        rf_gnt = 1'b1;
        tick();
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
